// File: rtl/stim_sequencer.sv
// Replays a programmed table of (delay, value) pairs onto a single stimulus line.
// Latency: entry k appears d_k+1 cycles after the previous one; no backpressure, writes/starts in RUN are dropped.
module stim_sequencer #(
    parameter int   DEPTH      = 8,
    parameter int   DW         = 8,
    parameter logic INIT_VALUE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_delay,
    input  logic                     wr_value,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     abort,
    output logic                     out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] idx;
    logic [DW-1:0] timer;
    logic [DW-1:0] delay_mem [DEPTH];
    logic          value_mem [DEPTH];
    logic          wr_ok;

    // Higher-priority commands in the same cycle swallow the write.
    assign wr_ok = wr_en && (state != RUN) && !full && !start && !clear;

    // Table storage has no reset so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            delay_mem[count[AW-1:0]] <= wr_delay;
            value_mem[count[AW-1:0]] <= wr_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= INIT_VALUE;
            count <= '0;
            idx   <= '0;
            timer <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            full  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        out <= value_mem[idx];
                        if ({1'b0, idx} == count - 1'b1) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idx   <= idx + 1'b1;
                            timer <= delay_mem[idx + 1'b1];
                        end
                    end
                end
                default: begin
                    if (clear) begin
                        count <= '0;
                        full  <= 1'b0;
                        done  <= 1'b0;
                        state <= IDLE;
                    end else if (start) begin
                        if (count != '0) begin
                            idx   <= '0;
                            timer <= delay_mem[0];
                            done  <= 1'b0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else if (wr_ok) begin
                        count <= count + 1'b1;
                        full  <= (count + 1'b1 == FULL_CNT);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench for stim_sequencer driving a modelled three-inverter chain.
module tb_stim_sequencer;
    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, wr_en = 1'b0, wr_value = 1'b0;
    logic          clear = 1'b0, start = 1'b0, abort = 1'b0;
    logic [DW-1:0] wr_delay = '0;
    logic          stim, busy, done, full;
    logic [$clog2(DEPTH):0] count;
    logic          inv1, inv2, chain_out;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int t;

    typedef struct {
        int          at;
        int          field;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    stim_sequencer #(.DEPTH(DEPTH), .DW(DW), .INIT_VALUE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_delay(wr_delay),
        .wr_value(wr_value), .clear(clear), .start(start), .abort(abort),
        .out(stim), .busy(busy), .done(done), .count(count), .full(full)
    );

    assign inv1      = ~stim;
    assign inv2      = ~inv1;
    assign chain_out = ~inv2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fname(input int f);
        case (f)
            0: return "out";
            1: return "busy";
            2: return "done";
            3: return "count";
            4: return "full";
            default: return "chain_out";
        endcase
    endfunction

    function automatic logic [31:0] sample(input int f);
        case (f)
            0: return {31'd0, stim};
            1: return {31'd0, busy};
            2: return {31'd0, done};
            3: return {28'd0, count};
            4: return {31'd0, full};
            default: return {31'd0, chain_out};
        endcase
    endfunction

    task automatic chk(input int at, input int f, input int v);
        exp_t e;
        e.at = at; e.field = f; e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drv(input logic rn, input logic we, input int wd, input logic wv,
                       input logic cl, input logic st, input logic ab);
        @(negedge clk);
        rst_n = rn; wr_en = we; wr_delay = wd[DW-1:0]; wr_value = wv;
        clear = cl; start = st; abort = ab;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every queued expectation at the edge it targets.
    initial forever begin
        logic [31:0] act;
        @(negedge clk);
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at == cyc) begin
                act = sample(sbq[i].field);
                n_cmp++;
                if (act !== sbq[i].val) begin
                    n_bad++;
                    $display("FAIL %s at edge %0d: got %0d, expected %0d",
                             fname(sbq[i].field), cyc, act, sbq[i].val);
                end
                sbq.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        for (int f = 0; f < 5; f++) chk(cyc + 1, f, 0);

        // Chain stimulus load
        drv(1, 1, 0, 0, 0, 0, 0);  chk(cyc + 1, 3, 1);
        drv(1, 1, 5, 1, 0, 0, 0);  chk(cyc + 1, 3, 2);
        drv(1, 1, 7, 0, 0, 0, 0);  chk(cyc + 1, 3, 3);
        drv(1, 1, 20, 1, 0, 0, 0); chk(cyc + 1, 3, 4);

        drv(1, 0, 0, 0, 0, 1, 0);
        t = cyc + 1;
        chk(t, 1, 1);
        chk(t + 1, 0, 0);
        chk(t + 6, 0, 0);  chk(t + 7, 0, 1);  chk(t + 7, 5, 0);
        chk(t + 14, 0, 1); chk(t + 15, 0, 0); chk(t + 15, 5, 1);
        chk(t + 35, 0, 0); chk(t + 35, 2, 0); chk(t + 35, 1, 1);
        chk(t + 36, 0, 1); chk(t + 36, 2, 1); chk(t + 36, 1, 0);
        chk(t + 5, 3, 4);  chk(t + 11, 3, 4); chk(t + 36, 3, 4);
        idle(2);
        drv(1, 1, 3, 1, 0, 0, 0);   // write during RUN, edge t+3
        drv(1, 0, 0, 0, 1, 0, 0);   // clear during RUN, edge t+4
        idle(5);
        drv(1, 0, 0, 0, 0, 1, 0);   // start during RUN, edge t+10
        idle(30);

        // Restart from DONE replays identical timing
        drv(1, 0, 0, 0, 0, 1, 0);
        t = cyc + 1;
        chk(t, 2, 0);      chk(t, 1, 1);      chk(t, 0, 1);
        chk(t + 1, 0, 0);  chk(t + 6, 0, 0);  chk(t + 7, 0, 1);
        chk(t + 15, 0, 0); chk(t + 35, 0, 0); chk(t + 36, 0, 1);
        chk(t + 36, 2, 1);
        idle(40);

        // Abort mid-run
        drv(0, 0, 0, 0, 0, 0, 0);
        chk(cyc + 1, 0, 0); chk(cyc + 1, 3, 0);
        drv(1, 1, 10, 1, 0, 0, 0); chk(cyc + 1, 3, 1);
        drv(1, 0, 0, 0, 0, 1, 0);
        t = cyc + 1;
        chk(t + 3, 1, 1);
        chk(t + 4, 1, 0); chk(t + 4, 2, 0); chk(t + 4, 0, 0);
        chk(t + 12, 0, 0); chk(t + 12, 2, 0); chk(t + 12, 3, 1);
        idle(3);
        drv(1, 0, 0, 0, 0, 0, 1);
        idle(12);

        // Reset in the middle of RUN
        drv(1, 0, 0, 0, 0, 1, 0);
        t = cyc + 1;
        chk(t + 2, 1, 1);
        for (int f = 0; f < 5; f++) chk(t + 3, f, 0);
        idle(2);
        drv(0, 0, 0, 0, 0, 0, 0);

        // Start with an empty table
        drv(1, 0, 0, 0, 0, 1, 0);
        t = cyc + 1;
        chk(t, 2, 1); chk(t, 1, 0); chk(t, 0, 0); chk(t + 1, 1, 0);
        idle(1);

        // start and wr_en together: write dropped
        drv(1, 1, 4, 1, 0, 1, 0);
        t = cyc + 1;
        chk(t, 3, 0); chk(t + 1, 3, 0); chk(t, 2, 1);
        idle(2);

        // Fill, overflow, clear
        drv(1, 0, 0, 0, 1, 0, 0);
        chk(cyc + 1, 3, 0); chk(cyc + 1, 2, 0);
        for (int k = 1; k <= DEPTH; k++) begin
            drv(1, 1, k, k[0], 0, 0, 0);
            chk(cyc + 1, 3, k);
            chk(cyc + 1, 4, (k == DEPTH) ? 1 : 0);
        end
        drv(1, 1, 9, 1, 0, 0, 0);
        chk(cyc + 1, 3, DEPTH); chk(cyc + 1, 4, 1);
        drv(1, 0, 0, 0, 1, 0, 0);
        chk(cyc + 1, 3, 0); chk(cyc + 1, 4, 0);

        // Maximum delay
        drv(1, 1, 255, 1, 0, 0, 0); chk(cyc + 1, 3, 1);
        drv(1, 0, 0, 0, 0, 1, 0);
        t = cyc + 1;
        chk(t + 255, 0, 0); chk(t + 255, 1, 1);
        chk(t + 256, 0, 1); chk(t + 256, 1, 0); chk(t + 256, 2, 1);
        idle(262);

        // Final held state after the maximum-delay replay
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL done after max-delay replay: got %0d, expected 1", done);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy after max-delay replay: got %0d, expected 0", busy);
        end
        n_cmp++;
        if (stim !== 1'b1) begin
            n_bad++;
            $display("FAIL out after max-delay replay: got %0d, expected 1", stim);
        end
        n_cmp++;
        if (chain_out !== ~stim) begin
            n_bad++;
            $display("FAIL chain_out not inverse of out: out=%0d chain_out=%0d", stim, chain_out);
        end
        n_cmp++;
        if (count !== 4'd1) begin
            n_bad++;
            $display("FAIL count after max-delay replay: got %0d, expected 1", count);
        end

        foreach (sbq[i]) begin
            n_bad++;
            $display("FAIL %s at edge %0d: never compared, expected %0d",
                     fname(sbq[i].field), sbq[i].at, sbq[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
